// File: rtl/rv_pkg.sv
// Shared types and constants for the RISC-V core pipeline.
// Holds result-select encoding, load funct3 codes and datapath widths.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_ADDR = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Load data alignment/extension and misalignment detection (combinational).
// Ports: word_i cache word, off_i byte offset, funct3_i size/sign -> data_o, misalign_o.
module load_extract
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o     = word_i;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {24'd0, byte_sel};
            F3_LH: begin
                data_o     = {{16{half_sel[15]}}, half_sel};
                misalign_o = off_i[0];
            end
            F3_LHU: begin
                data_o     = {16'd0, half_sel};
                misalign_o = off_i[0];
            end
            F3_LW:  misalign_o = (off_i != 2'd0);
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register and writeback select; drives register file write port.
// Ports: MEM-side capture inputs, rf_we/wa/wd, wb_valid, misalign, instret (WB_INSTRET_EN).
module writeback_stage
    import rv_pkg::*;
#(
    parameter int DATA = XLEN,
    parameter int ADDR = REG_ADDR
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mem_valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            reg_write_i,
    input  logic [ADDR-1:0] rd_i,
    input  logic [1:0]      result_src_i,
    input  logic [2:0]      funct3_i,
    input  logic [DATA-1:0] alu_result_i,
    input  logic [DATA-1:0] pc_plus4_i,
    input  logic [DATA-1:0] load_word_i,
    output logic            rf_we_o,
    output logic [ADDR-1:0] rf_wa_o,
    output logic [DATA-1:0] rf_wd_o,
    output logic            wb_valid_o,
    output logic            misalign_o,
    output logic [63:0]     instret_o
);

    logic            valid_q, valid_d;
    logic            capture;
    logic            reg_write_q;
    logic [ADDR-1:0] rd_q;
    logic [1:0]      src_q;
    logic [2:0]      funct3_q;
    logic [DATA-1:0] alu_q;
    logic [DATA-1:0] pc4_q;
    logic [DATA-1:0] lw_q;
    logic [DATA-1:0] ld_data;
    logic            ld_mis;
    logic            misalign;

    // Stalled MEM instruction is retired once: WB gets bubbles until release.
    assign valid_d = mem_valid_i & ~stall_i & ~flush_i;
    assign capture = mem_valid_i & ~stall_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            src_q       <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            lw_q        <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                reg_write_q <= reg_write_i;
                rd_q        <= rd_i;
                src_q       <= result_src_i;
                funct3_q    <= funct3_i;
                alu_q       <= alu_result_i;
                pc4_q       <= pc_plus4_i;
                lw_q        <= load_word_i;
            end
        end
    end

    load_extract u_load_extract (
        .word_i     (lw_q),
        .off_i      (alu_q[1:0]),
        .funct3_i   (funct3_q),
        .data_o     (ld_data),
        .misalign_o (ld_mis)
    );

    assign misalign = valid_q & (src_q == RES_LOAD) & ld_mis;

    // Reserved select 11 falls through to the ALU result.
    always_comb begin
        rf_wd_o = alu_q;
        unique case (1'b1)
            (src_q == RES_LOAD): rf_wd_o = ld_data;
            (src_q == RES_PC4):  rf_wd_o = pc4_q;
            default:             rf_wd_o = alu_q;
        endcase
    end

    assign rf_we_o    = valid_q & reg_write_q & (rd_q != '0) & ~misalign;
    assign rf_wa_o    = rd_q;
    assign wb_valid_o = valid_q;
    assign misalign_o = misalign;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    assign instret_d = instret_q + 64'(valid_q & ~misalign);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule
